spi_pattern_checker: RTL and testbench
======================================

SPI_PATTERN_CHECKER -- requirements
Module: spi_pattern_checker

Interface
REQ-001 Parameter DATA, default 8: word width in bits.
REQ-002 Parameter FIFO_DEPTH, default 16: depth of the source FIFO; sets the usedw width to $clog2(FIFO_DEPTH).
REQ-003 Parameter PATTERN_LEN, default 9: number of words per frame, range 2..256.
REQ-004 Parameter START_VAL, default 8'h31: expected value of word 0 of each frame.
REQ-005 Parameter STEP, default 1: increment between consecutive expected words.
REQ-006 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port rdata, input, DATA bits: FIFO read data, valid one cycle after rd.
REQ-009 Port rd, output, 1 bit: FIFO read strobe.
REQ-010 Port usedw, input, $clog2(FIFO_DEPTH) bits: FIFO fill level; 0 means empty.
REQ-011 Port enable, input, 1 bit: level; allows new reads.
REQ-012 Port clear, input, 1 bit: synchronous clear of the pattern position, counters and flags.
REQ-013 Port check, output, 1 bit: sticky mismatch flag.
REQ-014 Port err_cnt, output, 16 bits: saturating mismatch count.
REQ-015 Port frame_cnt, output, 16 bits: wrapping count of completed frames.
REQ-016 Port done, output, 1 bit: one-cycle pulse when the last word of a frame is compared.

Function
REQ-017 FSM states: IDLE, READ, CMP.
- IDLE -> READ when enable=1 and usedw>0.
- READ -> CMP unconditionally.
- CMP -> READ when enable=1 and usedw>0; otherwise CMP -> IDLE.
REQ-018 rd SHALL be 1 only in READ, and only for one cycle per word; maximum throughput is one word every 2 cycles.
REQ-019 In CMP, rdata SHALL be compared with exp = (START_VAL + idx*STEP) mod 2^DATA, where idx is the in-frame position, width $clog2(PATTERN_LEN).
REQ-020 On a mismatch in CMP:
- check SHALL be set to 1 and remain set until clear or reset;
- err_cnt SHALL increment, saturating at 16'hFFFF.
REQ-021 In CMP, idx SHALL increment; at idx = PATTERN_LEN-1 it SHALL wrap to 0, frame_cnt SHALL increment (wrapping at 16'hFFFF -> 0), and done SHALL pulse for 1 cycle.
REQ-022 The expected value SHALL be held in a register and updated by adding STEP, with no multiplier; on wrap it SHALL be reloaded with START_VAL.
REQ-023 clear=1, in any state, SHALL on the next edge:
- force the FSM to IDLE, idx to 0 and exp to START_VAL;
- force check, err_cnt, frame_cnt and done to 0;
- drive rd=0.
A read in flight is discarded, without a compare.
REQ-024 If clear and a CMP mismatch occur in the same cycle, clear SHALL win.
REQ-025 If enable is deasserted during READ, the word in flight SHALL still be compared in CMP before the FSM returns to IDLE; idx SHALL be retained for resumption.
REQ-026 No read SHALL be issued while usedw=0; the FSM waits in IDLE without timeout.

Reset
REQ-027 With rst=0, asynchronously:
- FSM = IDLE, idx = 0, exp = START_VAL;
- rd = 0, check = 0, err_cnt = 0, frame_cnt = 0, done = 0;
- capture registers = 0.
REQ-028 Reset release SHALL take effect at the first rising edge after rst goes to 1.

Configuration
REQ-029 With macro SPI_CHECK_CAPTURE_EN defined, the block SHALL add these output ports:
- err_exp, DATA bits: expected value at the first mismatch since clear/reset;
- err_got, DATA bits: received value at the first mismatch;
- err_pos, 8 bits: idx at the first mismatch.
These ports are frozen after the first mismatch.
REQ-030 Without SPI_CHECK_CAPTURE_EN, these ports and their registers SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package spi_check_pkg SHALL hold:
- the FSM state enum type (IDLE/READ/CMP);
- the counter width constant CNT_W=16;
- the saturation constant.
REQ-032 Sub-module spi_pattern_gen SHALL produce exp, with inputs step, wrap and load and output last (idx = PATTERN_LEN-1); the rest of the logic sits in the top.

Verification
REQ-033 Defaults; push 31..39 hex; hold enable=1 -> rd pulses 9 times, 2 cycles apart, check=0, done pulses once, frame_cnt=1.
REQ-034 Push 31,32,AA,34..39 -> check=1 from the third CMP onward, err_cnt=1; with the macro defined: err_exp=33, err_got=AA, err_pos=2.
REQ-035 DATA=8, START_VAL=F0, STEP=8, PATTERN_LEN=4; push F0,F8,00,08 twice -> check=0 (wrap mod 256), frame_cnt=2.
REQ-036 Feed the FIFO one word per 5 cycles -> rd never asserts while usedw=0, and every word is compared exactly once.
REQ-037 Assert clear during READ of word 4 -> next cycle FSM=IDLE and all counters 0; the next word is compared against 31.
REQ-038 Assert rst low in CMP with a mismatch pending -> all outputs 0 immediately, and err_cnt stays 0 after release.

Source files
------------

// File: rtl/spi_check_pkg.sv
// Shared types and constants for the SPI pattern checker.
package spi_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CMP  = 2'd2
    } state_e;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

endpackage

// File: rtl/spi_pattern_gen.sv
// Expected-word generator: walks START_VAL, START_VAL+STEP, ... and restarts each frame.
module spi_pattern_gen #(
    parameter int              DATA        = 8,
    parameter int              PATTERN_LEN = 9,
    parameter logic [DATA-1:0] START_VAL   = 'h31,
    parameter int unsigned     STEP        = 1,
    parameter int              IDX_W       = $clog2(PATTERN_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             wrap,
    input  logic             load,
    output logic [DATA-1:0]  exp,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATTERN_LEN - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DATA-1:0]  exp_q, exp_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            exp_q <= START_VAL;
        end else begin
            idx_q <= idx_d;
            exp_q <= exp_d;
        end
    end

    // Running add instead of idx*STEP; the natural DATA-bit overflow gives the mod 2^DATA.
    always_comb begin
        idx_d = idx_q;
        exp_d = exp_q;
        if (load || wrap) begin
            idx_d = '0;
            exp_d = START_VAL;
        end else if (step) begin
            idx_d = idx_q + IDX_W'(1);
            exp_d = exp_q + DATA'(STEP);
        end
    end

    assign exp  = exp_q;
    assign idx  = idx_q;
    assign last = (idx_q == LAST_IDX);

endmodule

// File: rtl/spi_pattern_checker.sv
// Reads words from a FIFO and checks them against a repeating arithmetic pattern.
// Define SPI_CHECK_CAPTURE_EN to add first-mismatch capture ports (err_exp/err_got/err_pos).
module spi_pattern_checker
    import spi_check_pkg::*;
#(
    parameter int              DATA        = 8,
    parameter int              FIFO_DEPTH  = 16,
    parameter int              PATTERN_LEN = 9,
    parameter logic [DATA-1:0] START_VAL   = 'h31,
    parameter int unsigned     STEP        = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA-1:0]               rdata,
    output logic                          rd,
    input  logic [$clog2(FIFO_DEPTH)-1:0] usedw,
    input  logic                          enable,
    input  logic                          clear,
    output logic                          check,
    output logic [CNT_W-1:0]              err_cnt,
    output logic [CNT_W-1:0]              frame_cnt,
    output logic                          done
`ifdef SPI_CHECK_CAPTURE_EN
    ,
    output logic [DATA-1:0]               err_exp,
    output logic [DATA-1:0]               err_got,
    output logic [7:0]                    err_pos
`endif
);

    localparam int IDX_W = $clog2(PATTERN_LEN);

    state_e           state_q, state_d;
    logic             check_q, check_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             done_q, done_d;

    logic             avail, cmp, mismatch, last;
    logic [DATA-1:0]  exp;
    logic [IDX_W-1:0] idx;

    assign avail    = (usedw != '0);
    // A clear in CMP discards the word: no compare, no counter update.
    assign cmp      = (state_q == CMP) && !clear;
    assign mismatch = cmp && (rdata != exp);

    spi_pattern_gen #(
        .DATA        (DATA),
        .PATTERN_LEN (PATTERN_LEN),
        .START_VAL   (START_VAL),
        .STEP        (STEP),
        .IDX_W       (IDX_W)
    ) u_gen (
        .clk  (clk),
        .rst  (rst),
        .step (cmp && !last),
        .wrap (cmp && last),
        .load (clear),
        .exp  (exp),
        .idx  (idx),
        .last (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && avail) state_d = READ;
            READ:    state_d = CMP;
            CMP:     state_d = (enable && avail) ? READ : IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    always_comb begin
        rd = (state_q == READ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            check_q     <= 1'b0;
            err_cnt_q   <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            check_q     <= check_d;
            err_cnt_q   <= err_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        check_d     = check_q;
        err_cnt_d   = err_cnt_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        if (clear) begin
            check_d     = 1'b0;
            err_cnt_d   = '0;
            frame_cnt_d = '0;
        end else begin
            if (mismatch) begin
                check_d = 1'b1;
                if (err_cnt_q != CNT_SAT) err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (cmp && last) begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
                done_d      = 1'b1;
            end
        end
    end

    assign check     = check_q;
    assign err_cnt   = err_cnt_q;
    assign frame_cnt = frame_cnt_q;
    assign done      = done_q;

`ifdef SPI_CHECK_CAPTURE_EN
    logic [DATA-1:0] err_exp_q, err_exp_d;
    logic [DATA-1:0] err_got_q, err_got_d;
    logic [7:0]      err_pos_q, err_pos_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_exp_q <= '0;
            err_got_q <= '0;
            err_pos_q <= '0;
        end else begin
            err_exp_q <= err_exp_d;
            err_got_q <= err_got_d;
            err_pos_q <= err_pos_d;
        end
    end

    // Only the first mismatch since clear/reset is kept; check_q marks it as taken.
    always_comb begin
        err_exp_d = err_exp_q;
        err_got_d = err_got_q;
        err_pos_d = err_pos_q;
        if (clear) begin
            err_exp_d = '0;
            err_got_d = '0;
            err_pos_d = '0;
        end else if (mismatch && !check_q) begin
            err_exp_d = exp;
            err_got_d = rdata;
            err_pos_d = 8'(idx);
        end
    end

    assign err_exp = err_exp_q;
    assign err_got = err_got_q;
    assign err_pos = err_pos_q;
`endif

endmodule

// File: tb/tb_spi_pattern_checker.sv
// Scoreboard bench for spi_pattern_checker: FIFO models feed two DUT configurations.
module tb_spi_pattern_checker;

    typedef struct packed {
        logic        chk;
        logic [15:0] err;
        logic [15:0] frm;
        logic        dn;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  rdata0, rdata1, pd0, pd1;
    logic [3:0]  usedw0, usedw1;
    logic        rd0, rd1, enable0, enable1, clear0, clear1, push0, push1;
    logic        check0, check1, done0, done1;
    logic [15:0] err0, err1, frm0, frm1;
`ifdef SPI_CHECK_CAPTURE_EN
    logic [7:0]  eexp0, egot0, epos0, eexp1, egot1, epos1;
`endif

    spi_pattern_checker u0 (
        .clk(clk), .rst(rst), .rdata(rdata0), .rd(rd0), .usedw(usedw0),
        .enable(enable0), .clear(clear0), .check(check0), .err_cnt(err0),
        .frame_cnt(frm0), .done(done0)
`ifdef SPI_CHECK_CAPTURE_EN
        , .err_exp(eexp0), .err_got(egot0), .err_pos(epos0)
`endif
    );

    spi_pattern_checker #(
        .DATA(8), .FIFO_DEPTH(16), .PATTERN_LEN(4), .START_VAL(8'hF0), .STEP(8)
    ) u1 (
        .clk(clk), .rst(rst), .rdata(rdata1), .rd(rd1), .usedw(usedw1),
        .enable(enable1), .clear(clear1), .check(check1), .err_cnt(err1),
        .frame_cnt(frm1), .done(done1)
`ifdef SPI_CHECK_CAPTURE_EN
        , .err_exp(eexp1), .err_got(egot1), .err_pos(epos1)
`endif
    );

    int n_chk = 0, n_pass = 0;
    int rd_cnt0 = 0, done_cnt0 = 0;
    logic [1:0] pipe0 = '0, pipe1 = '0;
    logic [7:0] q0[$], q1[$];
    res_t sb0[$], sb1[$];
    int m_idx[2], m_err[2], m_frm[2];
    bit m_chk[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void model_reset(input int i);
        m_idx[i] = 0; m_err[i] = 0; m_frm[i] = 0; m_chk[i] = 0;
    endfunction

    // Reference: exp = (START + idx*STEP) mod 256, computed directly.
    function automatic res_t model(input int i, input logic [7:0] d);
        res_t r;
        int e, len;
        e   = (i == 0) ? ('h31 + m_idx[i]) % 256 : ('hF0 + m_idx[i] * 8) % 256;
        len = (i == 0) ? 9 : 4;
        if (d != e[7:0]) begin
            m_chk[i] = 1;
            if (m_err[i] < 65535) m_err[i]++;
        end
        r.dn = (m_idx[i] == len - 1);
        if (r.dn) begin
            m_idx[i] = 0;
            m_frm[i] = (m_frm[i] + 1) % 65536;
        end else m_idx[i]++;
        r.chk = m_chk[i];
        r.err = 16'(m_err[i]);
        r.frm = 16'(m_frm[i]);
        return r;
    endfunction

    always @(posedge clk) begin
        if (rd0 && q0.size() != 0) rdata0 <= q0.pop_front();
        if (push0) q0.push_back(pd0);
        usedw0 <= 4'(q0.size());
        if (rd1 && q1.size() != 0) rdata1 <= q1.pop_front();
        if (push1) q1.push_back(pd1);
        usedw1 <= 4'(q1.size());
    end

    // Status is compared two samples after each rd (after the CMP edge).
    always @(posedge clk) begin
        res_t r;
        #3;
        if (!rst) pipe0 = '0;
        else begin
            if (pipe0[1]) begin
                if (sb0.size() == 0) chk("sb0_underflow", sb0.size(), 1);
                else begin
                    r = sb0.pop_front();
                    chk("cmp0", {check0, err0, frm0, done0}, r);
                end
            end
            if (done0) done_cnt0++;
            if (rd0) begin
                rd_cnt0++;
                chk("rd0_nonempty", usedw0 != 0, 1);
                chk("rd0_gap", pipe0[0], 0);
            end
            pipe0 = {pipe0[0], rd0};
            if (clear0) pipe0 = '0;
        end
    end

    always @(posedge clk) begin
        res_t r;
        #3;
        if (!rst) pipe1 = '0;
        else begin
            if (pipe1[1]) begin
                if (sb1.size() == 0) chk("sb1_underflow", sb1.size(), 1);
                else begin
                    r = sb1.pop_front();
                    chk("cmp1", {check1, err1, frm1, done1}, r);
                end
            end
            if (rd1) chk("rd1_gap", pipe1[0], 0);
            pipe1 = {pipe1[0], rd1};
            if (clear1) pipe1 = '0;
        end
    end

    task automatic push_word(input int i, input logic [7:0] d, input bit ex);
        if (i == 0) begin
            push0 = 1'b1; pd0 = d;
            if (ex) sb0.push_back(model(0, d));
        end else begin
            push1 = 1'b1; pd1 = d;
            if (ex) sb1.push_back(model(1, d));
        end
        @(negedge clk);
        push0 = 1'b0; push1 = 1'b0;
    endtask

    task automatic wait_drain(input int i);
        int n = 0;
        while (n < 300 && ((i == 0) ? (sb0.size() != 0 || pipe0 != 0 || q0.size() != 0)
                                    : (sb1.size() != 0 || pipe1 != 0 || q1.size() != 0))) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain%0d", i), n < 300, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_dut0();
        clear0 = 1'b1;
        @(negedge clk);
        clear0 = 1'b0;
        model_reset(0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; enable0 = 0; enable1 = 0; clear0 = 0; clear1 = 0;
        push0 = 0; push1 = 0; pd0 = '0; pd1 = '0;
        model_reset(0); model_reset(1);
        #2 rst = 1'b0;
        #1;
        chk("rst_rd", rd0, 0);
        chk("rst_check", check0, 0);
        chk("rst_err", err0, 0);
        chk("rst_frame", frm0, 0);
        chk("rst_done", done0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // One clean frame
        enable0 = 1'b1; rd_cnt0 = 0; done_cnt0 = 0;
        for (int k = 0; k < 9; k++) push_word(0, 8'(8'h31 + k), 1);
        wait_drain(0);
        chk("f1_rd_cnt", rd_cnt0, 9);
        chk("f1_done_cnt", done_cnt0, 1);
        chk("f1_frame", frm0, 1);
        chk("f1_check", check0, 0);

        // Corrupted third word
        for (int k = 0; k < 9; k++) push_word(0, (k == 2) ? 8'hAA : 8'(8'h31 + k), 1);
        wait_drain(0);
        chk("f2_check", check0, 1);
        chk("f2_err", err0, 1);
        chk("f2_frame", frm0, 2);
`ifdef SPI_CHECK_CAPTURE_EN
        chk("cap_exp", eexp0, 8'h33);
        chk("cap_got", egot0, 8'hAA);
        chk("cap_pos", epos0, 2);
`endif

        // Wrapping arithmetic on the second configuration
        enable1 = 1'b1;
        for (int f = 0; f < 2; f++) begin
            push_word(1, 8'hF0, 1); push_word(1, 8'hF8, 1);
            push_word(1, 8'h00, 1); push_word(1, 8'h08, 1);
        end
        wait_drain(1);
        chk("wrap_check", check1, 0);
        chk("wrap_frame", frm1, 2);

        // Slow feed: one word every 5 cycles
        clear_dut0();
        chk("clr_check", check0, 0);
        rd_cnt0 = 0;
        for (int k = 0; k < 9; k++) begin
            push_word(0, 8'(8'h31 + k), 1);
            repeat (4) @(negedge clk);
        end
        wait_drain(0);
        chk("slow_rd_cnt", rd_cnt0, 9);
        chk("slow_frame", frm0, 1);

        // Clear during the fifth READ; that word is never compared
        clear_dut0();
        enable0 = 1'b0;
        push_word(0, 8'h31, 1); push_word(0, 8'h32, 1); push_word(0, 8'hAA, 1);
        push_word(0, 8'h34, 1); push_word(0, 8'h35, 0);
        enable0 = 1'b1;
        n = 0;
        for (int t = 0; t < 50 && n < 5; t++) begin
            @(negedge clk);
            if (rd0) n++;
        end
        chk("clr_reached_rd5", n, 5);
        chk("clr_pre_err", err0, 1);
        clear0 = 1'b1;
        @(negedge clk);
        clear0 = 1'b0;
        model_reset(0);
        sb0.delete();
        chk("clr_rd", rd0, 0);
        chk("clr_err", err0, 0);
        chk("clr_chk", check0, 0);
        chk("clr_frm", frm0, 0);
        chk("clr_done", done0, 0);
        push_word(0, 8'h31, 1); push_word(0, 8'h32, 1);
        wait_drain(0);
        chk("post_clr_check", check0, 0);

        // Reset while a mismatching word sits in CMP
        push_word(0, 8'h00, 0);
        n = 0;
        while (n < 50 && !rd0) begin @(negedge clk); n++; end
        chk("rst_reached_rd", rd0, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_check", check0, 0);
        chk("arst_err", err0, 0);
        chk("arst_frame", frm0, 0);
        chk("arst_rd", rd0, 0);
        chk("arst_done", done0, 0);
        chk("arst_frame1", frm1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset(0); model_reset(1);
        repeat (4) @(negedge clk);
        chk("rel_err", err0, 0);
        chk("rel_check", check0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
